// File: rtl/muldiv_unit.sv
// Iterative RV32/64 M-extension multiply/divide unit.
// Radix-2 shift-add multiply, restoring divide, optional sign-fix cycle.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int SIGNED_FIX = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     dvs;
  logic [XLEN-1:0]     res_q;
  logic [2:0]          op;
  logic                neg;

  logic                accept, byp, last;
  logic                sg1, sg2, s1, s2, neg_in;
  logic [XLEN-1:0]     mag1, mag2, byp_res;
  logic                div_zero, div_ovf;
  logic [2*XLEN-1:0]   st_in, st_out;
  logic [XLEN-1:0]     st_b;
  logic                st_div;
  logic [XLEN:0]       sum, rsh, diff;

  function automatic logic [XLEN-1:0] fin(
    input logic [2*XLEN-1:0] v,
    input logic [2:0]        f,
    input logic              n
  );
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   h;
    if (!f[2]) begin
      p = n ? -v : v;
      h = (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
      return h;
    end
    h = f[1] ? v[2*XLEN-1:XLEN] : v[XLEN-1:0];
    return n ? -h : h;
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = out_valid ? res_q : '0;
  assign accept    = in_valid && in_ready && !kill;
  assign last      = (cnt == CW'(1));

  // Operand conditioning: magnitudes plus sign of the final result
  always_comb begin
    sg1      = (func3 == 3'b001) || (func3 == 3'b010) ||
               (func3 == 3'b100) || (func3 == 3'b110);
    sg2      = (func3 == 3'b001) || (func3 == 3'b100) ||
               (func3 == 3'b110);
    s1       = sg1 && op1[XLEN-1];
    s2       = sg2 && op2[XLEN-1];
    mag1     = s1 ? -op1 : op1;
    mag2     = s2 ? -op2 : op2;
    neg_in   = (func3[2] && func3[1]) ? s1 : (s1 ^ s2);
    div_zero = func3[2] && (op2 == '0);
    div_ovf  = func3[2] && !func3[0] && (&op2) &&
               (op1 == {1'b1, {(XLEN-1){1'b0}}});
    byp      = div_zero || div_ovf;
    byp_res  = '0;
    if (div_zero)
      byp_res = func3[1] ? op1 : '1;
    else if (div_ovf)
      byp_res = func3[1] ? '0 : op1;
  end

  // One radix-2 step; the accept edge performs the first one
  always_comb begin
    st_in  = in_ready ? {{XLEN{1'b0}}, mag1} : acc;
    st_b   = in_ready ? mag2 : dvs;
    st_div = in_ready ? func3[2] : op[2];
    sum    = {1'b0, st_in[2*XLEN-1:XLEN]} +
             (st_in[0] ? {1'b0, st_b} : '0);
    rsh    = st_in[2*XLEN-1:XLEN-1];
    diff   = rsh - {1'b0, st_b};
    st_out = {sum, st_in[XLEN-1:1]};
    if (st_div) begin
      if (rsh >= {1'b0, st_b})
        st_out = {diff[XLEN-1:0], st_in[XLEN-2:0], 1'b1};
      else
        st_out = {rsh[XLEN-1:0], st_in[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = byp ? DONE : CALC;
      CALC: begin
        if (kill)
          state_nx = IDLE;
        else if (last)
          state_nx = (SIGNED_FIX != 0) ? FIX : DONE;
      end
      FIX:  state_nx = kill ? IDLE : DONE;
      DONE: if (kill || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      dvs   <= '0;
      op    <= '0;
      neg   <= 1'b0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      unique case (1'b1)
        accept && byp: res_q <= byp_res;
        accept && !byp: begin
          acc <= st_out;
          dvs <= mag2;
          op  <= func3;
          neg <= neg_in;
          cnt <= CW'(XLEN-1);
        end
        (state == CALC) && !kill: begin
          acc <= st_out;
          cnt <= cnt - CW'(1);
          if (last && SIGNED_FIX == 0)
            res_q <= fin(st_out, op, neg);
        end
        (state == FIX) && !kill: res_q <= fin(acc, op, neg);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus random checks of muldiv_unit against an arithmetic model.
// Latency counts clock edges from the accept edge up to out_valid.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32), .SIGNED_FIX(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .op1(op1), .op2(op2),
    .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b
  );
    longint sa, sb, ub, q;
    logic [63:0] p;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b
  );
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    func3 = f;
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    func3 = 3'($urandom);
    op1 = $urandom;
    op2 = $urandom;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    logic [31:0] exp_r;
    logic [31:0] held;
    int n;
    exp_r = model(f, a, b);
    out_ready = 1'b0;
    start_op(f, a, b);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("lat f%0d", f), 64'(n), 64'(exp_lat(f, a, b)));
    chk($sformatf("res f%0d %h %h", f, a, b), {32'd0, result},
        {32'd0, exp_r});
    held = result;
    if (stall > 0) in_valid = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_res", {32'd0, result}, {32'd0, held});
      chk("stall_rdy", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("hs_ovalid", {63'd0, out_valid}, 64'd0);
    chk("hs_busy", {63'd0, busy}, 64'd0);
    chk("hs_result", {32'd0, result}, 64'd0);
  endtask

  task automatic no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    func3 = '0;
    op1 = '0;
    op2 = '0;
    kill = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd5, 32'd5, 32'd0, 0);
    do_op(3'd7, 32'd5, 32'd0, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 10);

    // kill during IDLE blocks the accept
    @(negedge clk);
    in_valid = 1'b1;
    kill = 1'b1;
    func3 = 3'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill = 1'b0;
    chk("kill_idle_busy", {63'd0, busy}, 64'd0);
    chk("kill_idle_rdy", {63'd0, in_ready}, 64'd1);

    // kill at CALC cycle 5
    start_op(3'd4, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_calc_busy", {63'd0, busy}, 64'd0);
    no_valid("kill_calc_nov", 40);

    // kill while the result is waiting
    start_op(3'd0, 32'd3, 32'd4);
    repeat (33) @(posedge clk);
    #1;
    chk("kill_done_pre", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_done_ov", {63'd0, out_valid}, 64'd0);
    chk("kill_done_res", {32'd0, result}, 64'd0);

    // reset at CALC cycle 12
    start_op(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_rdy", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_res", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_valid("mid_rst_nov", 40);

    do_op(3'd4, 32'd100, 32'd7, 0);

    for (int k = 0; k < 40; k++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) ra = 32'($urandom_range(0, 300));
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      do_op(rf, ra, rb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
